// File: rtl/pushbutton_scanner.sv
// Multi-key pushbutton scanner: per-key two-flop synchroniser and debouncer,
// single-key acceptance FSM with a press strobe and optional auto-repeat.
module pushbutton_scanner #(
  parameter int NUM_KEYS        = 4,
  parameter int CODE_W          = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] key,
  output logic [CODE_W-1:0]   pushbuttons,
  output logic                pushButtonPressed,
  output logic                key_strobe,
  output logic                multi_key
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PC_W    = $clog2(NUM_KEYS + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LOCKOUT
  } state_t;

  logic [NUM_KEYS-1:0] db_w;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic            s1_q;
      logic            s2_q;
      logic            db_bit_q;
      logic [DB_W-1:0] cnt_q;

      always_ff @(posedge clock) begin
        if (!resetn) begin
          s1_q     <= 1'b1;
          s2_q     <= 1'b1;
          db_bit_q <= 1'b1;
          cnt_q    <= '0;
        end else begin
          s1_q <= key[gi];
          s2_q <= s1_q;
          // Any sample agreeing with the debounced level restarts the count.
          if (s2_q == db_bit_q) begin
            cnt_q <= '0;
          end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_bit_q <= s2_q;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end

      assign db_w[gi] = db_bit_q;
    end
  endgenerate

  logic [PC_W-1:0]   pcount_c;
  logic [CODE_W-1:0] idx_c;

  always_comb begin
    pcount_c = '0;
    idx_c    = '0;
    // Descending scan so the lowest pressed index ends up in idx_c.
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (!db_w[i]) begin
        pcount_c = pcount_c + PC_W'(1);
        idx_c    = CODE_W'(i);
      end
    end
  end

  logic [PC_W-1:0]   pcount_q;
  logic [CODE_W-1:0] idx_q;
  logic              multi_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pcount_q <= '0;
      idx_q    <= '0;
      multi_q  <= 1'b0;
    end else begin
      pcount_q <= pcount_c;
      idx_q    <= idx_c;
      multi_q  <= (pcount_c > PC_W'(1));
    end
  end

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              pressed_q, pressed_d;
  logic              strobe_q, strobe_d;
  logic [REP_W-1:0]  rep_q, rep_d;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= IDLE;
      code_q    <= '0;
      pressed_q <= 1'b0;
      strobe_q  <= 1'b0;
      rep_q     <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pressed_q <= pressed_d;
      strobe_q  <= strobe_d;
      rep_q     <= rep_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    pressed_d = pressed_q;
    strobe_d  = 1'b0;
    rep_d     = rep_q;
    case (state_q)
      IDLE: begin
        pressed_d = 1'b0;
        if (pcount_q == PC_W'(1)) begin
          state_d   = HELD;
          code_d    = idx_q;
          pressed_d = 1'b1;
          strobe_d  = 1'b1;
          rep_d     = REP_W'(REPEAT_DELAY);
        end else if (pcount_q > PC_W'(1)) begin
          state_d = LOCKOUT;
        end
      end
      HELD: begin
        if (pcount_q == '0) begin
          state_d   = IDLE;
          pressed_d = 1'b0;
        end else if ((pcount_q > PC_W'(1)) || (idx_q != code_q)) begin
          state_d   = LOCKOUT;
          pressed_d = 1'b0;
        end else if (REPEAT_DELAY != 0) begin
          // Reaching zero this cycle fires the repeat and reloads the period.
          if (rep_q <= REP_W'(1)) begin
            strobe_d = 1'b1;
            rep_d    = REP_W'(REPEAT_PERIOD);
          end else begin
            rep_d = rep_q - REP_W'(1);
          end
        end
      end
      LOCKOUT: begin
        pressed_d = 1'b0;
        if (pcount_q == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        pressed_d = 1'b0;
      end
    endcase
  end

  assign pushbuttons       = code_q;
  assign pushButtonPressed = pressed_q;
  assign key_strobe        = strobe_q;
  assign multi_key         = multi_q;

endmodule

// File: doc/pushbutton_scanner.md
Name: pushbutton_scanner

Overview:
- Parametrised successor to the 4-key calculator pushbutton decoder.
- Synchronises and debounces NUM_KEYS active-low keys and accepts only single-key presses.
- Outputs a binary key code, a held-level flag, a one-cycle press strobe and optional auto-repeat strobes.
- Feeds the calculator control FSM (backspace/MS/MR/MC and future function keys), replacing raw per-clock decoding.

Parameters:
- NUM_KEYS, 4, number of active-low key inputs (2..16).
- CODE_W, 2, width of key code; must equal ceil(log2(NUM_KEYS)).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a level change (>=1).
- REPEAT_DELAY, 0, cycles from first strobe to first repeat strobe while held; 0 disables auto-repeat.
- REPEAT_PERIOD, 4, cycles between subsequent repeat strobes (>=1); ignored when REPEAT_DELAY=0.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- key  in  NUM_KEYS  raw buttons; 0 = pressed; asynchronous to clock.
- pushbuttons  out  CODE_W  index of the accepted key; held until next accepted press.
- pushButtonPressed  out  1  level: a single debounced key is currently accepted and held.
- key_strobe  out  1  one-cycle pulse per accepted press and per repeat.
- multi_key  out  1  level: more than one debounced key is pressed.

Behaviour:
- Interface: one clock (clock), synchronous active-low reset (resetn).
- Reset, sampled at the clock edge while resetn=0: sync regs and debounced state = all 1s (released); counters = 0; FSM = IDLE; pushbuttons = 0; pushButtonPressed = 0; key_strobe = 0; multi_key = 0.
- Synchroniser: two flops per key. Each key has its own debounce counter.
  - While the sync output differs from the debounced bit, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the difference still present, the debounced bit flips and the counter clears.
  - Any sample equal to the debounced bit clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Latency: a clean key change first sampled at edge E yields key_strobe high after edge E+DEBOUNCE_CYCLES+3, for exactly one cycle.
- Derived combinational terms: pcount = number of debounced pressed keys; multi_key registered from (pcount>1).
- FSM states:
  - IDLE
    - pcount==1: go to HELD. Load pushbuttons with the key index, set pushButtonPressed=1, pulse key_strobe, load repeat counter with REPEAT_DELAY.
    - pcount>1: go to LOCKOUT.
  - HELD
    - Same single key held: if REPEAT_DELAY!=0, decrement the repeat counter. At 0, pulse key_strobe and reload with REPEAT_PERIOD.
    - pcount==0: go to IDLE, clear pushButtonPressed.
    - pcount>1, or a different single key (no release observed): go to LOCKOUT, clear pushButtonPressed, no strobe.
  - LOCKOUT
    - No strobes; pushButtonPressed=0.
    - Leave to IDLE only when pcount==0.
- pushbuttons retains its last accepted code through IDLE and LOCKOUT.
- Simultaneous debounced press of two keys in one cycle: LOCKOUT, no strobe.
- Release and re-press of the same key: a new strobe, after the debounce interval on both edges.
- Key held through reset: after resetn rises it is treated as a new press; strobe after the normal latency.
- Reset asserted mid-repeat: the strobe is suppressed in that same cycle; all state returns to reset values.
- Counter widths are sized from parameters; no counter wraps; repeat counter saturates at 0 before reload.

Test Plan:
- NUM_KEYS=4, DEBOUNCE_CYCLES=4: drive key=4'b1011 at edge 10, hold -> key_strobe high only after edge 17; pushbuttons=2'd2; pushButtonPressed=1 from the same edge.
- Bounce: key[0] low for 3 cycles, high for 2, then low steady -> exactly one strobe, 7 cycles after the steady low begins; pushbuttons=0.
- Multi-key: press key[1], then key[3] while held -> single strobe with code 1; then pushButtonPressed=0 and multi_key=1. Release key[3] only -> no strobe. Release all -> IDLE.
- Auto-repeat, REPEAT_DELAY=10, REPEAT_PERIOD=3: hold key[2] for 30 cycles -> strobes at t0, t0+10, t0+13, t0+16, ... until release.
- Reset: assert resetn=0 during HELD -> next cycle all outputs 0. Key still held at release of resetn -> fresh strobe after DEBOUNCE_CYCLES+3 edges.
- NUM_KEYS=16, CODE_W=4: sweep each key individually -> pushbuttons equals the key index, one strobe per press, multi_key never set.
